simd_pem_array: RTL
===================

// Module: simd_pem_array
// PURPOSE
//  Parametrised N-lane SIMD processing-element memory array: per-lane input staging register
//  feeding a per-lane 1W/2R register file, with broadcast/masked writes and a hardware clear sequencer.
//  Sits between the SIMD control unit's operand fetch and the PE ALUs.
//  Generalises the fixed 3-lane, 8-bit, 16-entry array to any lane count, width and depth.
//  Adds write-accept handshake, registered read-valid and clear-on-reset/clear-on-request.
// PARAMETERS
//  NUM_PE   3   number of lanes (PEMs), >=1
//  DATA_W   8   bits per register
//  ADDR_W   4   register address bits; DEPTH = 2**ADDR_W entries per lane
// PORTS
//  clk        in   1               single clock, all state on rising edge
//  rst        in   1               synchronous, active-high reset
//  clr_req    in   1               pulse: start clear sequence (honoured only in IDLE)
//  busy       out  1               1 while clear sequence runs
//  wr_valid   in   1               write request
//  wr_ready   out  1               = ~busy; write accepted when wr_valid & wr_ready
//  wr_bcast   in   1               1: lane 0's addr/data written to every masked lane
//  wr_mask    in   NUM_PE          per-lane write enable
//  wr_addr    in   NUM_PE*ADDR_W   packed per-lane write address, lane i at [i*ADDR_W +: ADDR_W]
//  wr_data    in   NUM_PE*DATA_W   packed per-lane write data
//  rd_en      in   1               read request (ignored while busy)
//  rd_addr_a  in   NUM_PE*ADDR_W   packed port-A read addresses
//  rd_addr_b  in   NUM_PE*ADDR_W   packed port-B read addresses
//  rd_valid   out  1               rd_data_a/b valid this cycle
//  rd_data_a  out  NUM_PE*DATA_W   packed port-A read data (registered)
//  rd_data_b  out  NUM_PE*DATA_W   packed port-B read data (registered)
// BEHAVIOUR
//  Reset: state<=CLEAR, clr_cnt<=0, staging valid<=0, rd_valid<=0, rd_data_a/b<=0; busy=1, wr_ready=0.
//  FSM states: CLEAR, IDLE.
//   CLEAR: each cycle all lanes write 0 to entry clr_cnt; clr_cnt++; at clr_cnt==DEPTH-1 -> IDLE next cycle.
//     Clear takes exactly DEPTH cycles; busy deasserts on first IDLE cycle.
//   IDLE: clr_req=1 -> CLEAR with clr_cnt<=0, staging valid<=0 (pending write dropped).
//   clr_req during CLEAR ignored (no restart); rst anytime restarts CLEAR from 0.
//  Write path (2 stages): accept at edge T -> staging reg holds {mask,addr,data} -> regfile written at T+1.
//   Data readable by a rd_en issued in the cycle after T+1; rd_data shows it one cycle later.
//   wr_bcast=1: every lane i with wr_mask[i]=1 uses lane-0 addr/data; mask still applies.
//   wr_mask[i]=0: lane i unchanged. wr_valid & wr_mask==0: accepted, no effect.
//  Read path: rd_en & ~busy at edge T -> rd_data_a/b, rd_valid=1 after T; otherwise rd_valid<=0, data holds.
//   Read and commit to same entry in same cycle: read returns OLD value (no bypass).
//   Ports A and B may address the same entry: both return same value.
//   rd_en while busy: rd_valid stays 0.
//  Addresses wrap naturally at DEPTH (no out-of-range case). All widths exact; no truncation.
//  A commit in the staging reg is allowed to complete on the cycle clr_req enters CLEAR? No: dropped.
// STRUCTURE
//  Package simd_pkg: default DATA_W/ADDR_W/NUM_PE localparams, FSM state enum {CLEAR, IDLE}.
//  Sub-module simd_pe_regfile (1 write, 2 registered-read ports, DATA_W x DEPTH), instantiated NUM_PE
//  times via generate; clear FSM, staging regs and broadcast mux live in the top.
// TESTING
//  1. rst 1 cycle, release -> busy=1 for exactly 16 cycles, wr_ready=0; all reads afterwards return 0.
//  2. Write lane0 addr3=0xA5, mask=001 at T; rd_en addr_a=3 at T+2 -> rd_data_a[7:0]=0xA5, rd_valid at T+3.
//  3. wr_bcast=1, mask=101, lane0 addr7 data0x3C -> lanes 0,2 entry7=0x3C, lane1 entry7 unchanged (0).
//  4. Same-cycle read/commit of entry 5 (old 0x11, new 0x22) -> read returns 0x11; next read 0x22.
//  5. clr_req in IDLE with write staged -> staged write dropped, busy=1 for 16 cycles, all entries 0.
//  6. rst asserted at clr_cnt=9 mid-clear -> clr_cnt restarts 0, busy held another full 16 cycles.

Source files
------------

// File: rtl/simd_pkg.sv
// Shared defaults and FSM encoding for the SIMD processing-element memory array.
package simd_pkg;
  localparam int NUM_PE_DEF = 3;
  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 4;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;
endpackage

// File: rtl/simd_pe_regfile.sv
// One lane's register file: a single write port and two registered read ports.
module simd_pe_regfile #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: the storage array has no reset; the clear sequencer zeroes it, which keeps it mappable to RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // A read sampled on the same edge as a write returns the old contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_a <= '0;
      rdata_b <= '0;
    end else if (re) begin
      rdata_a <= mem[raddr_a];
      rdata_b <= mem[raddr_b];
    end
  end
endmodule

// File: rtl/simd_pem_array.sv
// N-lane SIMD PE memory array: staging register, broadcast/masked writes, clear sequencer,
// and one dual-read register file per lane.
module simd_pem_array
  import simd_pkg::*;
#(
  parameter int NUM_PE = NUM_PE_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr_req,
  output logic                     busy,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic                     wr_bcast,
  input  logic [NUM_PE-1:0]        wr_mask,
  input  logic [NUM_PE*ADDR_W-1:0] wr_addr,
  input  logic [NUM_PE*DATA_W-1:0] wr_data,
  input  logic                     rd_en,
  input  logic [NUM_PE*ADDR_W-1:0] rd_addr_a,
  input  logic [NUM_PE*ADDR_W-1:0] rd_addr_b,
  output logic                     rd_valid,
  output logic [NUM_PE*DATA_W-1:0] rd_data_a,
  output logic [NUM_PE*DATA_W-1:0] rd_data_b
);
  localparam int DEPTH = 1 << ADDR_W;

  state_t              state;
  logic [ADDR_W-1:0]   clr_cnt;
  logic                stg_valid;
  logic [NUM_PE-1:0]   stg_mask;
  logic [ADDR_W-1:0]   stg_addr [NUM_PE];
  logic [DATA_W-1:0]   stg_data [NUM_PE];

  logic wr_fire;
  logic rd_fire;
  logic commit;

  assign busy     = (state == CLEAR);
  assign wr_ready = ~busy;
  assign wr_fire  = wr_valid & wr_ready;
  assign rd_fire  = rd_en & ~busy;
  // A staged write is dropped if a clear request (or reset) arrives on its commit edge.
  assign commit   = stg_valid & ~clr_req & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= CLEAR;
      clr_cnt   <= '0;
      stg_valid <= 1'b0;
      rd_valid  <= 1'b0;
    end else begin
      rd_valid <= rd_fire;
      case (state)
        CLEAR: begin
          clr_cnt   <= clr_cnt + 1'b1;
          stg_valid <= 1'b0;
          if (clr_cnt == ADDR_W'(DEPTH - 1)) state <= IDLE;
        end
        IDLE: begin
          if (clr_req) begin
            state     <= CLEAR;
            clr_cnt   <= '0;
            stg_valid <= 1'b0;
          end else begin
            stg_valid <= wr_fire;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

  // Payload is only meaningful while stg_valid is set, so it carries no reset.
  // Broadcast is resolved here so each lane's commit path is a plain register.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      stg_mask <= wr_mask;
      for (int i = 0; i < NUM_PE; i++) begin
        stg_addr[i] <= wr_bcast ? wr_addr[0 +: ADDR_W] : wr_addr[i*ADDR_W +: ADDR_W];
        stg_data[i] <= wr_bcast ? wr_data[0 +: DATA_W] : wr_data[i*DATA_W +: DATA_W];
      end
    end
  end

  for (genvar g = 0; g < NUM_PE; g++) begin : g_lane
    logic              lane_we;
    logic [ADDR_W-1:0] lane_waddr;
    logic [DATA_W-1:0] lane_wdata;

    assign lane_we    = busy | (commit & stg_mask[g]);
    assign lane_waddr = busy ? clr_cnt : stg_addr[g];
    assign lane_wdata = busy ? '0 : stg_data[g];

    simd_pe_regfile #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
    ) u_regfile (
      .clk     (clk),
      .rst     (rst),
      .we      (lane_we),
      .waddr   (lane_waddr),
      .wdata   (lane_wdata),
      .re      (rd_fire),
      .raddr_a (rd_addr_a[g*ADDR_W +: ADDR_W]),
      .raddr_b (rd_addr_b[g*ADDR_W +: ADDR_W]),
      .rdata_a (rd_data_a[g*DATA_W +: DATA_W]),
      .rdata_b (rd_data_b[g*DATA_W +: DATA_W])
    );
  end
endmodule
